// File: rtl/uart_pkg.sv
// Shared types and constants for the CPU-facing UART responder.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // Control-bus device codes decoded by the CPU for this port.
  localparam logic [3:0] DEV_UART_TARGET = 4'h6;
  localparam logic [3:0] DEV_UART_ASRC   = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RIDLE  = 2'd0,
    RSTART = 2'd1,
    RDATA  = 2'd2,
    RSTOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; wrap-bit pointers distinguish full from empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_responder.sv
// Device-side CPU UART port: buffered 8N1 transmitter and single-byte receive
// holding register with the _flag_do/_flag_di status lines the CPU polls.
module uart_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       _uart_in,
  input  logic [7:0] uart_wdata,
  input  logic       _uart_out,
  output logic [7:0] uart_rdata,
  output logic       _flag_do,
  output logic       _flag_di,
  output logic       rx_ovr,
  output logic       rx_ferr,
  output logic       txd,
  input  logic       rxd
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [UART_DATA_BITS-1:0] w_fifo_dout;
  logic                      w_tx_pop;
  logic                      w_tx_bit_end;

  tx_state_t                 r_tx_state;
  logic [BAUD_W-1:0]         r_tx_baud;
  logic [2:0]                r_tx_bit;
  logic [UART_DATA_BITS-1:0] r_tx_shift;
  logic                      r_txd;

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_tx_fifo (
    .clk     (clk),
    .mr      (mr),
    .i_push  (!_uart_in),
    .i_din   (uart_wdata),
    .i_pop   (w_tx_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_tx_bit_end = (r_tx_state != IDLE) && (r_tx_baud == BAUD_LAST);
  assign w_tx_pop     = !w_fifo_empty &&
                        ((r_tx_state == IDLE) || ((r_tx_state == STOP) && w_tx_bit_end));

  // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_tx_state <= IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      if ((r_tx_state == IDLE) || w_tx_bit_end) r_tx_baud <= '0;
      else                                      r_tx_baud <= r_tx_baud + 1'b1;

      case (r_tx_state)
        IDLE: if (w_tx_pop) begin
          r_tx_state <= START;
          r_tx_shift <= w_fifo_dout;
          r_txd      <= 1'b0;
        end
        START: if (w_tx_bit_end) begin
          r_tx_state <= DATA;
          r_txd      <= r_tx_shift[0];
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= '0;
        end
        DATA: if (w_tx_bit_end) begin
          if (r_tx_bit == BIT_LAST) begin
            r_tx_state <= STOP;
            r_txd      <= 1'b1;
          end else begin
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 1'b1;
          end
        end
        STOP: if (w_tx_bit_end) begin
          // Chain straight into the next start bit so queued frames leave back-to-back.
          if (w_tx_pop) begin
            r_tx_state <= START;
            r_tx_shift <= w_fifo_dout;
            r_txd      <= 1'b0;
          end else begin
            r_tx_state <= IDLE;
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  logic                      r_rx_s1;
  logic                      r_rx_s2;
  logic                      r_rx_s3;
  rx_state_t                 r_rx_state;
  logic [BAUD_W-1:0]         r_rx_baud;
  logic [2:0]                r_rx_bit;
  logic [UART_DATA_BITS-1:0] r_rx_shift;
  logic [UART_DATA_BITS-1:0] r_rdata;
  logic                      r_flag_di;
  logic                      r_rx_ovr;
  logic                      r_rx_ferr;
  logic                      w_rx_fall;
  logic                      w_rx_tick;
  logic                      w_rx_read;

  // r_rx_s3 is the previous synchronised level, used only for edge detection.
  assign w_rx_fall = r_rx_s3 && !r_rx_s2;
  assign w_rx_read = !_uart_out && !r_flag_di;
  assign w_rx_tick = ((r_rx_state == RSTART) && (r_rx_baud == BAUD_HALF)) ||
                     (((r_rx_state == RDATA) || (r_rx_state == RSTOP)) && (r_rx_baud == BAUD_LAST));

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RIDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rdata    <= '0;
      r_flag_di  <= 1'b1;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;

      if ((r_rx_state == RIDLE) || w_rx_tick) r_rx_baud <= '0;
      else                                    r_rx_baud <= r_rx_baud + 1'b1;

      // A read clears first; a commit or error on the same edge overrides below.
      if (w_rx_read) begin
        r_flag_di <= 1'b1;
        r_rx_ovr  <= 1'b0;
        r_rx_ferr <= 1'b0;
      end

      case (r_rx_state)
        RIDLE: if (w_rx_fall) r_rx_state <= RSTART;
        RSTART: if (w_rx_tick) begin
          if (r_rx_s2) begin
            r_rx_state <= RIDLE;
          end else begin
            r_rx_state <= RDATA;
            r_rx_bit   <= '0;
          end
        end
        RDATA: if (w_rx_tick) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[UART_DATA_BITS-1:1]};
          if (r_rx_bit == BIT_LAST) r_rx_state <= RSTOP;
          else                      r_rx_bit   <= r_rx_bit + 1'b1;
        end
        RSTOP: if (w_rx_tick) begin
          r_rx_state <= RIDLE;
          if (!r_rx_s2) begin
            r_rx_ferr <= 1'b1;
          end else if (r_flag_di || w_rx_read) begin
            r_rdata   <= r_rx_shift;
            r_flag_di <= 1'b0;
          end else begin
            r_rx_ovr  <= 1'b1;
          end
        end
        default: r_rx_state <= RIDLE;
      endcase
    end
  end

  assign txd        = r_txd;
  assign _flag_do   = w_fifo_full;
  assign _flag_di   = r_flag_di;
  assign uart_rdata = r_rdata;
  assign rx_ovr     = r_rx_ovr;
  assign rx_ferr    = r_rx_ferr;

endmodule
